// File: rtl/clint_bus_adapter.sv
// clint_bus_adapter
//   Bridges a single-outstanding CPU load/store port onto a CLINT register
//   window. Legal accesses become one-cycle CLINT requests. Load data is
//   lane-extracted from the 64-bit CLINT word and sign- or zero-extended.
//   Illegal or timed-out accesses return an error response with zero data.
//
// Ports
//   clk, reset_n           : clock; asynchronous active-low reset
//   cpu_req_*              : CPU request (valid/ready, addr, wdata, we, funct3)
//   cpu_rsp_*              : CPU response (valid/ready, rdata, err)
//   clint_req_*            : CLINT request (valid, offset addr, wdata, we, size)
//                            plus the CLINT ready and rdata inputs
module clint_bus_adapter #(
    parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic [31:0] cpu_req_addr,
    input  logic [31:0] cpu_req_wdata,
    input  logic        cpu_req_we,
    input  logic [2:0]  cpu_req_funct3,
    output logic        cpu_rsp_valid,
    input  logic        cpu_rsp_ready,
    output logic [31:0] cpu_rsp_rdata,
    output logic        cpu_rsp_err,
    output logic        clint_req_valid,
    output logic [15:0] clint_req_addr,
    output logic [63:0] clint_req_wdata,
    output logic        clint_req_we,
    output logic [2:0]  clint_req_size,
    input  logic        clint_req_ready,
    input  logic [63:0] clint_req_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       funct3_q;
    logic             accept;
    logic             in_window;
    logic             req_illegal;
    logic             wait_timeout;
    logic [31:0]      rdata_shifted;
    logic [31:0]      load_data;

    assign accept       = cpu_req_valid && cpu_req_ready;
    assign wait_timeout = (wait_cnt == CNT_LAST);

    // Unsigned offset from the base; addresses below the base wrap to a huge
    // offset, so one upper-bits test covers both window edges.
    assign in_window = ((cpu_req_addr - BASE_ADDR) >> 16) == 32'd0;

    always_comb begin
        req_illegal = !in_window;
        if (cpu_req_funct3 == 3'b011 || cpu_req_funct3 == 3'b110 ||
            cpu_req_funct3 == 3'b111)
            req_illegal = 1'b1;
        if (cpu_req_we && cpu_req_funct3[2])
            req_illegal = 1'b1;
        if (cpu_req_funct3[1:0] == 2'b01 && cpu_req_addr[0])
            req_illegal = 1'b1;
        if (cpu_req_funct3[1:0] == 2'b10 && cpu_req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
    end

    // The latched CLINT-side address/we double as the access context for
    // formatting the returned load data.
    always_comb begin
        rdata_shifted = 32'(clint_req_rdata >> {clint_req_addr[2:0], 3'b000});
        load_data     = '0;
        if (!clint_req_we) begin
            case (funct3_q)
                3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
                3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
                3'b010:  load_data = rdata_shifted;
                3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
                3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
                default: load_data = '0;
            endcase
        end
    end

    // State register and WAIT-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_illegal ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (clint_req_ready || wait_timeout) state_next = RESP;
            RESP:    if (cpu_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, computed from the upcoming state so each one lines
    // up with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_req_ready   <= 1'b0;
            cpu_rsp_valid   <= 1'b0;
            cpu_rsp_rdata   <= '0;
            cpu_rsp_err     <= 1'b0;
            clint_req_valid <= 1'b0;
            clint_req_addr  <= '0;
            clint_req_wdata <= '0;
            clint_req_we    <= 1'b0;
            clint_req_size  <= '0;
            funct3_q        <= '0;
        end else begin
            cpu_req_ready   <= (state_next == IDLE);
            clint_req_valid <= (state_next == ISSUE);
            if (accept) begin
                clint_req_addr  <= cpu_req_addr[15:0];
                clint_req_wdata <= {32'h0, cpu_req_wdata};
                clint_req_we    <= cpu_req_we;
                clint_req_size  <= {1'b0, cpu_req_funct3[1:0]};
                funct3_q        <= cpu_req_funct3;
            end
            case (state)
                IDLE: begin
                    if (accept && req_illegal) begin
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_err   <= 1'b1;
                        cpu_rsp_rdata <= '0;
                    end
                end
                WAIT: begin
                    if (clint_req_ready) begin
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_err   <= 1'b0;
                        cpu_rsp_rdata <= load_data;
                    end else if (wait_timeout) begin
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_err   <= 1'b1;
                        cpu_rsp_rdata <= '0;
                    end
                end
                RESP: begin
                    if (cpu_rsp_ready) begin
                        cpu_rsp_valid <= 1'b0;
                        cpu_rsp_err   <= 1'b0;
                        cpu_rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
